// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH cycles from accept to complete.
// start is honoured only in IDLE/DONE and ignored while busy; results hold in DONE until the next accept.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             complete,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             complete_q, complete_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  // One extra bit on the shifted remainder keeps every register bit live; the sign is exact.
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] dvd_sh;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quot_d     = quot_q;
    remo_d     = remo_q;
    complete_d = complete_q;
    busy_d     = busy_q;
    dbz_d      = dbz_q;

    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    trial  = rem_sh - {2'b00, dvs_q};
    dvd_sh = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d      = dividend;
          dvs_d      = divisor;
          rem_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          complete_d = 1'b0;
          dbz_d      = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        rem_d = trial[WIDTH+1] ? rem_sh[WIDTH:0] : trial[WIDTH:0];
        dvd_d = dvd_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_d     = (dvs_q == '0) ? '1 : dvd_sh;
          remo_d     = rem_d[WIDTH-1:0];
          dbz_d      = (dvs_q == '0);
          complete_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      remo_q     <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quot_q     <= quot_d;
      remo_q     <= remo_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
      dbz_q      <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign complete    = complete_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the GCD datapath. It answers a one-cycle `start` request by computing `quotient` and `remainder` of `dividend / divisor`, one quotient bit per clock, then raises `complete` and holds it. It is the responder side of the start/complete handshake the GCD controller drives for each Euclid step. It also serves any other block needing a small sequential divide.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..16.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request pulse, sampled each rising edge; honoured only in IDLE or DONE.
- `dividend`  input  WIDTH  unsigned dividend, sampled on the accepting edge only.
- `divisor`  input  WIDTH  unsigned divisor, sampled on the accepting edge only.
- `quotient`  output  WIDTH  registered result; valid while `complete`=1.
- `remainder`  output  WIDTH  registered result; valid while `complete`=1.
- `complete`  output  1  level, high in DONE until the next accepted `start` or `reset`.
- `busy`  output  1  high in BUSY.
- `div_by_zero`  output  1  high with `complete` when the latched divisor was 0.

## Operation
- States: IDLE, BUSY, DONE. After reset the block is in IDLE.
- Reset values: `quotient`=0, `remainder`=0, `complete`=0, `busy`=0, `div_by_zero`=0, and the internal iteration counter is 0.
- IDLE, `start`=1: on that edge the block does the following.
  - Latches `dividend` into the shift register and `divisor` into the divisor register.
  - Clears the partial remainder, which is WIDTH+1 bits wide.
  - Sets counter=0 and goes to BUSY.
- IDLE, `start`=0: the block stays in IDLE.
- BUSY, one iteration per edge:
  - Shift {partial remainder, dividend register} left by 1.
  - Compute trial = partial remainder − {0, divisor} at WIDTH+1 bits.
  - If trial is non-negative (MSB=0), the partial remainder becomes trial and the shifted-in quotient bit is 1. Otherwise the partial remainder is kept and the quotient bit is 0.
  - Increment the counter.
- After iteration WIDTH (counter = WIDTH−1 at that edge), the block moves to DONE on the same edge:
  - loads `quotient` and `remainder[WIDTH-1:0]`;
  - sets `complete`=1 and `busy`=0.
- Divisor = 0: the block runs the same WIDTH iterations, then forces `quotient` to all ones, `remainder`=dividend and `div_by_zero`=1.
- DONE, `start`=0: all outputs are held.
- DONE, `start`=1: the block behaves exactly as an IDLE accept. On that edge `complete` and `div_by_zero` clear, and `quotient`/`remainder` hold their old values until the new result loads.
- `start` during BUSY is ignored. The in-flight operands and result are unaffected.
- `reset` has priority over `start` in every state. A reset during BUSY aborts the operation, and the aborted result is never presented.

## Timing
- Accept edge E0: `start`=1 sampled in IDLE or DONE.
- After E0: `complete`=0 and `busy`=1.
- Iterations occur on edges E1..EWIDTH.
- After EWIDTH: `complete`=1, `busy`=0, results valid. Latency is WIDTH cycles from the accept edge (8 for WIDTH=8).
- `complete` deasserts on the accept edge. An initiator that pulses `start` and then waits for `complete`=1 therefore never sees a stale completion.
- Back-to-back operation: `start` asserted in the first DONE cycle gives a throughput of one result per WIDTH+1 cycles.
- Operands may change freely after E0.
- Outputs are purely registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then no `start` for 5 cycles -> all outputs 0, `busy`=0.
- WIDTH=8: 200/7 with `start` for 1 cycle -> 8 edges later `quotient`=28, `remainder`=4, `complete`=1, `div_by_zero`=0.
- Corner operands, each as a separate operation:
  - 13/13 -> 1, 0
  - 5/9 -> 0, 5
  - 255/1 -> 255, 0
  - 0/3 -> 0, 0
- 77/0 -> `quotient`=255, `remainder`=77, `div_by_zero`=1, latency 8. A following 9/2 -> 4, 1 with `div_by_zero`=0.
- 100/9 started, then `start` with 50/5 pulsed at E3 -> result 11, 1 at E8, and the second request is ignored.
  - Then `start` 50/5 in DONE -> `complete` drops at the next edge, and 10, 0 appear 8 edges later.
- Euclid sequence as the GCD controller drives it: 48/18, then 18/12, then 12/6 -> remainders 12, 6, 0.
  - `reset` asserted at E4 of a further operation -> IDLE next edge, all outputs 0, `complete` never rises.
